aftab_irq_requester: RTL and testbench
======================================

Name: aftab_irq_requester

Overview:
- Peripheral-side interrupt request generator. It drives the interrupt line and the cause ID that the core's interrupt-capture flop latches.
- It collects rising-edge events from NUM_SRC sources into a pending register and applies an enable mask.
- It selects the lowest-index enabled pending source and holds a request/acknowledge/done handshake with the core until the handler completes.
- It sits between the peripheral event lines and the AFTAB interrupt unit.

Parameters:
- NUM_SRC, 8, number of interrupt sources (2..32)
- ID_W, 3, width of the cause ID; must satisfy 2**ID_W >= NUM_SRC

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- srcEvent  input  NUM_SRC  source event levels, synchronous to clk; a 0->1 transition is an event
- maskIn  input  NUM_SRC  new enable mask
- maskLoad  input  1  loads maskIn into the enable register
- clearAll  input  1  synchronous flush: clears pending and the FSM (core zero/flush)
- irqAck  input  1  core accepted the current request
- irqDone  input  1  core finished the handler (mret)
- irqReq  output  1  interrupt request to the core
- irqId  output  ID_W  cause ID of the current request
- pending  output  NUM_SRC  pending register, for debug/CSR read
- busy  output  1  high in REQ or SERVICE

Behaviour:
- Reset (async) clears:
  - srcPrev = 0, pending = 0, enable = 0 (all masked).
  - State = IDLE, irqReq = 0, irqId = 0, busy = 0.
- Edge detect:
  - rise = srcEvent & ~srcPrev; srcPrev <= srcEvent every cycle.
  - pending[i] is set at the edge where rise[i] = 1.
- Enable register: enable <= maskIn when maskLoad = 1. Masked sources still become pending but are never selected.
- Selection: cand = pending & enable. Selected ID = lowest index i with cand[i] = 1, computed combinationally.
- FSM, registered outputs:
  - IDLE: irqReq = 0. If cand != 0: latch irqId = selected ID and go to REQ.
  - REQ: irqReq = 1, irqId held stable. The request is never withdrawn, even if the source is later masked. On irqAck: clear pending[irqId] and go to SERVICE.
  - SERVICE: irqReq = 0, irqId held. On irqDone: go to IDLE. IDLE always lasts at least one cycle, so consecutive requests are separated by one or more cycles of irqReq = 0.
- Latency:
  - Edge E0: srcEvent first sampled high, pending set.
  - Edge E1: REQ entered; irqReq = 1 after E1, provided the source is enabled and the FSM was in IDLE.
- Precedence and boundary cases:
  - clearAll has priority over all other updates: pending = 0, state = IDLE, irqReq = 0. enable and srcPrev are unaffected.
  - A new rise on source irqId in the same cycle as irqAck: set wins, so pending stays 1 and the event is not lost.
  - irqAck in IDLE or SERVICE is ignored.
  - irqDone in IDLE or REQ is ignored.
  - irqAck and irqDone together in REQ: only the ack takes effect; done is consumed only in SERVICE.
  - A re-event from an already pending source is absorbed, with no counting.
  - A source held continuously high produces exactly one event.
  - maskLoad during REQ or SERVICE only affects the next selection.
  - NUM_SRC < 2**ID_W: unused IDs are never produced.
- busy = (state != IDLE).

Decomposition:
- Shared package aftab_irq_pkg holds:
  - state encoding IDLE = 2'b00, REQ = 2'b01, SERVICE = 2'b10
  - defaults for NUM_SRC and ID_W
- One sub-module: aftab_irq_prio_enc, a parameterised combinational lowest-index priority encoder.
  - Inputs: cand[NUM_SRC].
  - Outputs: id[ID_W] and valid.
- The FSM, pending, enable and edge registers live in the top module.

Test Plan:
1. Reset, maskLoad with 8'hFF, then srcEvent[5] rises before edge E0 -> pending = 8'h20; irqReq = 1, irqId = 5 after E1; irqAck -> pending = 0, SERVICE; irqDone -> IDLE, busy = 0.
2. srcEvent[6] and srcEvent[2] rise in the same cycle, with mask 8'hFF -> irqId = 2 first; after ack and done, one or more idle cycles, then irqId = 6.
3. Mask 8'h01, srcEvent[3] rises -> pending = 8'h08 with irqReq = 0; maskLoad 8'h08 -> irqReq = 1 one edge later, irqId = 3.
4. In REQ with irqId = 4, srcEvent[4] falls and then rises again in the same cycle as irqAck -> pending[4] remains 1; after irqDone a second request with irqId = 4 follows.
5. In SERVICE with pending = 8'h81, assert clearAll -> pending = 0, state IDLE, irqReq = 0 next cycle; enable is unchanged.
6. Assert rst asynchronously mid-REQ -> irqReq, irqId, pending and busy drop to 0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/aftab_irq_pkg.sv
// Purpose: shared FSM state encoding and default sizing for the AFTAB interrupt requester.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aftab_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } irq_state_t;

    localparam int DEF_NUM_SRC = 8;
    localparam int DEF_ID_W    = 3;

endpackage

// File: rtl/aftab_irq_requester_if.sv
// Purpose: bundles peripheral event/mask inputs, core handshake and status outputs of the requester.
// Latency: n/a (wiring only).
// Backpressure: n/a; slave = requester side, master = peripheral/core side driving it.
interface aftab_irq_requester_if
    import aftab_irq_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int ID_W    = DEF_ID_W
);
    logic [NUM_SRC-1:0] srcEvent;
    logic [NUM_SRC-1:0] maskIn;
    logic               maskLoad;
    logic               clearAll;
    logic               irqAck;
    logic               irqDone;
    logic               irqReq;
    logic [ID_W-1:0]    irqId;
    logic [NUM_SRC-1:0] pending;
    logic               busy;

    modport master (
        output srcEvent, maskIn, maskLoad, clearAll, irqAck, irqDone,
        input  irqReq, irqId, pending, busy
    );

    modport slave (
        input  srcEvent, maskIn, maskLoad, clearAll, irqAck, irqDone,
        output irqReq, irqId, pending, busy
    );
endinterface

// File: rtl/aftab_irq_prio_enc.sv
// Purpose: lowest-index priority encoder over the enabled-pending vector.
// Latency: combinational.
// Backpressure: none.
// Ports: cand (candidate bits), id (index of lowest set bit), valid (any bit set).
module aftab_irq_prio_enc #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 3
) (
    input  logic [NUM_SRC-1:0] cand,
    output logic [ID_W-1:0]    id,
    output logic               valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                id    = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aftab_irq_requester.sv
// Purpose: collects source rising edges into pending bits, masks them, and runs the req/ack/done handshake with the core.
// Latency: edge seen at E0 sets pending; irqReq rises after E1 when enabled and idle.
// Backpressure: one request outstanding; further events wait in pending until the handler completes.
// Ports: clk, rst (async, active-high); bus (slave modport): srcEvent, maskIn, maskLoad, clearAll,
//        irqAck, irqDone in; irqReq, irqId, pending, busy out.
module aftab_irq_requester
    import aftab_irq_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic                 clk,
    input  logic                 rst,
    aftab_irq_requester_if.slave bus
);

    logic [NUM_SRC-1:0] srcPrev;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] pendR;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] ackClr;
    logic [ID_W-1:0]    selId;
    logic               selVld;
    irq_state_t         state;
    logic               irqReqR;
    logic [ID_W-1:0]    irqIdR;
    logic               busyR;

    assign rise = bus.srcEvent & ~srcPrev;
    assign cand = pendR & enable;

    // Bit of the request being acknowledged; a same-cycle rise re-sets it below.
    assign ackClr = (state == REQ && bus.irqAck)
                  ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << irqIdR)
                  : '0;

    aftab_irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .cand  (cand),
        .id    (selId),
        .valid (selVld)
    );

    // Edge history and enable mask are untouched by clearAll.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srcPrev <= '0;
            enable  <= '0;
        end else begin
            srcPrev <= bus.srcEvent;
            if (bus.maskLoad) begin
                enable <= bus.maskIn;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            irqReqR <= 1'b0;
            irqIdR  <= '0;
            busyR   <= 1'b0;
            pendR   <= '0;
        end else if (bus.clearAll) begin
            state   <= IDLE;
            irqReqR <= 1'b0;
            busyR   <= 1'b0;
            pendR   <= '0;
        end else begin
            pendR <= (pendR & ~ackClr) | rise;
            unique case (state)
                IDLE: begin
                    if (selVld) begin
                        state   <= REQ;
                        irqReqR <= 1'b1;
                        irqIdR  <= selId;
                        busyR   <= 1'b1;
                    end
                end
                // Request stays up until acked, regardless of later mask changes.
                REQ: begin
                    if (bus.irqAck) begin
                        state   <= SERVICE;
                        irqReqR <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (bus.irqDone) begin
                        state <= IDLE;
                        busyR <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    irqReqR <= 1'b0;
                    busyR   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irqReq  = irqReqR;
    assign bus.irqId   = irqIdR;
    assign bus.pending = pendR;
    assign bus.busy    = busyR;

endmodule

// File: tb/tb_aftab_irq_requester.sv
// Purpose: self-checking bench for aftab_irq_requester: vector table, directed corner sequences, random run vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_aftab_irq_requester;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    aftab_irq_requester_if #(.NUM_SRC(8), .ID_W(3)) bus ();

    aftab_irq_requester #(.NUM_SRC(8), .ID_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] src;
        logic [7:0] mask;
        logic       ml;
        logic       ack;
        logic       done;
        logic       eReq;
        logic [2:0] eId;
        logic [7:0] ePend;
        logic       eBusy;
    } vec_t;

    vec_t tbl [19];

    // Reference model state
    logic [7:0] mPend, mEn, mPrev;
    int         mCur;
    bit         mAcked;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] src, input logic [7:0] mask, input logic ml,
                         input logic ca, input logic ack, input logic done);
        bus.srcEvent = src;
        bus.maskIn   = mask;
        bus.maskLoad = ml;
        bus.clearAll = ca;
        bus.irqAck   = ack;
        bus.irqDone  = done;
    endtask

    function automatic vec_t mk(input logic [7:0] src, input logic [7:0] mask, input logic ml,
                                input logic ack, input logic done, input logic eReq,
                                input logic [2:0] eId, input logic [7:0] ePend, input logic eBusy);
        vec_t v;
        v.src = src; v.mask = mask; v.ml = ml; v.ack = ack; v.done = done;
        v.eReq = eReq; v.eId = eId; v.ePend = ePend; v.eBusy = eBusy;
        return v;
    endfunction

    // Model: one owner id (or -1); the core owns it until done, the request is
    // visible until acked. Selection uses the pre-edge pending/enable.
    task automatic model_edge(input logic [7:0] src, input logic [7:0] mask, input logic ml,
                              input logic ca, input logic ack, input logic done);
        logic [7:0] r;
        r = src & ~mPrev;
        if (ca) begin
            mPend  = 8'h00;
            mCur   = -1;
            mAcked = 1'b0;
        end else begin
            if (mCur < 0) begin
                for (int i = 0; i < 8; i++) begin
                    if (mCur < 0 && mPend[i] && mEn[i]) mCur = i;
                end
                mAcked = 1'b0;
            end else if (!mAcked) begin
                if (ack) begin
                    mPend[mCur] = 1'b0;
                    mAcked = 1'b1;
                end
            end else if (done) begin
                mCur = -1;
            end
            mPend = mPend | r;
        end
        if (ml) mEn = mask;
        mPrev = src;
    endtask

    logic [7:0] rSrc, rMask;
    logic       rMl, rCa, rAck, rDone;

    initial begin
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed stimulus table: plan items 1-3, one row per clock.
        //            src    mask   ml   ack  done  req  id    pend   busy
        tbl[0]  = mk(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        tbl[1]  = mk(8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h20, 1'b0);
        tbl[2]  = mk(8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1);
        tbl[3]  = mk(8'h20, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 1'b1);
        tbl[4]  = mk(8'h20, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        tbl[5]  = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        tbl[6]  = mk(8'h44, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h44, 1'b0);
        tbl[7]  = mk(8'h44, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 8'h44, 1'b1);
        tbl[8]  = mk(8'h44, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'h40, 1'b1);
        tbl[9]  = mk(8'h44, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h40, 1'b0);
        tbl[10] = mk(8'h44, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 8'h40, 1'b1);
        tbl[11] = mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 8'h00, 1'b1);
        tbl[12] = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        tbl[13] = mk(8'h08, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0);
        tbl[14] = mk(8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0);
        tbl[15] = mk(8'h08, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0);
        tbl[16] = mk(8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1);
        tbl[17] = mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 1'b1);
        tbl[18] = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

        // Reset state
        #12;
        chk("rst_req", 32'(bus.irqReq), 32'd0);
        chk("rst_id", 32'(bus.irqId), 32'd0);
        chk("rst_pend", 32'(bus.pending), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].src, tbl[i].mask, tbl[i].ml, 1'b0, tbl[i].ack, tbl[i].done);
            step();
            chk($sformatf("tbl%0d_req", i), 32'(bus.irqReq), 32'(tbl[i].eReq));
            chk($sformatf("tbl%0d_pend", i), 32'(bus.pending), 32'(tbl[i].ePend));
            chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].eBusy));
            if (tbl[i].eBusy) chk($sformatf("tbl%0d_id", i), 32'(bus.irqId), 32'(tbl[i].eId));
        end

        // Re-event on the acknowledged source in the ack cycle is kept.
        drive(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0); step();
        drive(8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); step();
        chk("re_pend_e0", 32'(bus.pending), 32'h10);
        step();
        chk("re_req", 32'(bus.irqReq), 32'd1);
        chk("re_id", 32'(bus.irqId), 32'd4);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); step();
        chk("re_req_held", 32'(bus.irqReq), 32'd1);
        drive(8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); step();
        chk("re_pend_kept", 32'(bus.pending), 32'h10);
        chk("re_svc_req", 32'(bus.irqReq), 32'd0);
        chk("re_svc_busy", 32'(bus.busy), 32'd1);
        drive(8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); step();
        chk("re_idle_req", 32'(bus.irqReq), 32'd0);
        drive(8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); step();
        chk("re_req2", 32'(bus.irqReq), 32'd1);
        chk("re_id2", 32'(bus.irqId), 32'd4);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); step();
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); step();
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); step();
        chk("re_done_pend", 32'(bus.pending), 32'h00);

        // clearAll in SERVICE with pending = 8'h81; enable survives.
        drive(8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); step();
        step();
        chk("ca_req_id", 32'(bus.irqId), 32'd0);
        drive(8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); step();
        drive(8'h81, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); step();
        chk("ca_pre_pend", 32'(bus.pending), 32'h81);
        chk("ca_pre_busy", 32'(bus.busy), 32'd1);
        drive(8'h81, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); step();
        chk("ca_pend", 32'(bus.pending), 32'h00);
        chk("ca_req", 32'(bus.irqReq), 32'd0);
        chk("ca_busy", 32'(bus.busy), 32'd0);
        drive(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); step();
        step();
        chk("ca_en_req", 32'(bus.irqReq), 32'd1);
        chk("ca_en_id", 32'(bus.irqId), 32'd1);
        drive(8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); step();
        drive(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); step();

        // Asynchronous reset mid-request.
        drive(8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); step();
        step();
        chk("ar_pre_req", 32'(bus.irqReq), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_req", 32'(bus.irqReq), 32'd0);
        chk("ar_id", 32'(bus.irqId), 32'd0);
        chk("ar_pend", 32'(bus.pending), 32'd0);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Random run against the model, starting from reset state.
        mPend = 8'h00; mEn = 8'h00; mPrev = 8'h00; mCur = -1; mAcked = 1'b0;
        rSrc = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) rSrc = rSrc ^ (8'($urandom) & 8'($urandom));
            rMask = 8'($urandom);
            rMl   = ($urandom_range(0, 15) == 0);
            rCa   = ($urandom_range(0, 63) == 0);
            rAck  = ($urandom_range(0, 2) == 0);
            rDone = ($urandom_range(0, 2) == 0);
            drive(rSrc, rMask, rMl, rCa, rAck, rDone);
            model_edge(rSrc, rMask, rMl, rCa, rAck, rDone);
            step();
            chk("rnd_req", 32'(bus.irqReq), 32'(mCur >= 0 && !mAcked));
            chk("rnd_busy", 32'(bus.busy), 32'(mCur >= 0));
            chk("rnd_pend", 32'(bus.pending), 32'(mPend));
            if (mCur >= 0) chk("rnd_id", 32'(bus.irqId), 32'(mCur));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
